ram_burst_ctrl: RTL and testbench

RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

---
 rtl/ram_burst_ctrl_if.sv | 36 +++
 rtl/ram_burst_ctrl.sv | 146 ++++++++++++++
 tb/tb_ram_burst_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_burst_ctrl_if.sv
// Bus bundle for ram_burst_ctrl: command channel, write/read beat streams and RAM port.
// The controller connects through the slave modport; its environment uses master.
interface ram_burst_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0] cmd_len;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  busy;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic                  ram_write_enb;
  logic                  ram_read_enb;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_data_out;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_data_out,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy,
           ram_data_in, ram_write_enb, ram_read_enb, ram_address
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_data_out,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy,
           ram_data_in, ram_write_enb, ram_read_enb, ram_address
  );
endinterface

// File: rtl/ram_burst_ctrl.sv
// Burst controller for a single-port RAM: write bursts stream straight into the RAM,
// read bursts return through a 2-entry FIFO sized to cover the 1-cycle RAM read latency.
module ram_burst_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  ram_burst_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  state_t                state_r;
  state_t                state_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH-1:0] beats_r;
  logic                  inflight_r;
  logic [DATA_WIDTH-1:0] fifo_r [2];
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  logic [1:0]            count_r;

  logic                  fifo_room_s;
  logic                  wr_hs_s;
  logic                  rd_issue_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  cmd_hs_s;

  // Handshake and RAM-issue qualifiers.
  always_comb begin
    fifo_room_s = ({1'b0, count_r} + {2'b00, inflight_r}) < 3'd2;
    cmd_hs_s    = (state_r == IDLE) && bus.cmd_valid;
    wr_hs_s     = (state_r == WRITE) && bus.wr_valid;
    rd_issue_s  = (state_r == READ) && fifo_room_s;
    push_s      = inflight_r;
    pop_s       = (count_r != 2'd0) && bus.rd_ready;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_nxt_s = bus.cmd_write ? WRITE : READ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        if (wr_hs_s && (beats_r == ADDR_ZERO)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WRITE;
        end
      end
      READ: begin
        if (rd_issue_s && (beats_r == ADDR_ZERO)) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = READ;
        end
      end
      DRAIN: begin
        if (!inflight_r && (count_r == 2'd0)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // cmd_ready is gated by reset so it stays low while reset is held.
  assign bus.cmd_ready     = (state_r == IDLE) && reset;
  assign bus.busy          = (state_r != IDLE);
  assign bus.wr_ready      = (state_r == WRITE);
  assign bus.rd_valid      = (count_r != 2'd0);
  assign bus.rd_data       = (count_r != 2'd0) ? fifo_r[rd_ptr_r] : DATA_ZERO;
  assign bus.ram_write_enb = wr_hs_s;
  assign bus.ram_read_enb  = rd_issue_s;
  assign bus.ram_address   = (wr_hs_s || rd_issue_s) ? addr_r : ADDR_ZERO;
  assign bus.ram_data_in   = wr_hs_s ? bus.wr_data : DATA_ZERO;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Address and remaining-beat counters; both wrap naturally at the address width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_r  <= ADDR_ZERO;
      beats_r <= ADDR_ZERO;
    end else if (cmd_hs_s) begin
      addr_r  <= bus.cmd_addr;
      beats_r <= bus.cmd_len;
    end else if (wr_hs_s || rd_issue_s) begin
      addr_r  <= addr_r + ADDR_ONE;
      beats_r <= beats_r - ADDR_ONE;
    end
  end

  // Read-return FIFO; an issue this cycle lands in the FIFO next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_r <= 1'b0;
      fifo_r[0]  <= DATA_ZERO;
      fifo_r[1]  <= DATA_ZERO;
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      count_r    <= 2'd0;
    end else begin
      inflight_r <= rd_issue_s;
      if (push_s) begin
        fifo_r[wr_ptr_r] <= bus.ram_data_out;
        wr_ptr_r         <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Self-checking bench for ram_burst_ctrl: directed burst table, hand-written reset
// sequences and random bursts checked against a flat memory image of the RAM.
module tb_ram_burst_ctrl;

  logic clk;
  logic reset;

  ram_burst_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  ram_burst_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAM: synchronous write, registered read data one cycle after the enable.
  logic [7:0] ram_mem [16];
  always @(posedge clk) begin
    if (bus.ram_write_enb) ram_mem[bus.ram_address] <= bus.ram_data_in;
    if (bus.ram_read_enb)  bus.ram_data_out <= ram_mem[bus.ram_address];
  end

  // Reference: what the RAM should contain, from the beats the bench has written.
  logic [7:0] ref_mem [16];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [3:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  int         wr_cyc_q  [$];
  logic [3:0] rd_iss_q  [$];
  logic [7:0] pop_q     [$];
  int first_re = -1;
  int first_rv = -1;
  int both_err = 0;
  int idle_err = 0;
  int ovf_err  = 0;

  logic [25:0] out_vec_s;
  assign out_vec_s = {bus.cmd_ready, bus.busy, bus.wr_ready, bus.rd_valid, bus.ram_write_enb,
                      bus.ram_read_enb, bus.rd_data, bus.ram_data_in, bus.ram_address};

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.ram_write_enb) begin
        wr_addr_q.push_back(bus.ram_address);
        wr_data_q.push_back(bus.ram_data_in);
        wr_cyc_q.push_back(cyc);
      end
      if (bus.ram_read_enb) begin
        rd_iss_q.push_back(bus.ram_address);
        if (first_re < 0) first_re = cyc;
      end
      if (bus.rd_valid && first_rv < 0) first_rv = cyc;
      if (bus.rd_valid && bus.rd_ready) pop_q.push_back(bus.rd_data);
      if (bus.ram_write_enb && bus.ram_read_enb) both_err++;
      if (!bus.ram_write_enb && !bus.ram_read_enb &&
          (bus.ram_address != 4'd0 || bus.ram_data_in != 8'd0)) idle_err++;
      if (int'(rd_iss_q.size()) - int'(pop_q.size()) > 2) ovf_err++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_idle_timeout"}, 0, 1);
  endtask

  task automatic wait_wr_ready();
    bit ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.wr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wr_ready_timeout", 0, 1);
  endtask

  task automatic write_burst(input logic [3:0] a, input logic [3:0] len, input logic [7:0] base,
                             input bit gap, input logic [3:0] exp_last);
    logic [3:0] ea;
    int n;
    n = int'(len);
    wait_idle("pre_write");
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = a; bus.cmd_len = len;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int i = 0; i <= n; i++) begin
      ea = a + 4'(i);
      bus.wr_valid = 1'b1;
      bus.wr_data  = base + 8'(i);
      ref_mem[ea]  = base + 8'(i);
      wait_wr_ready();
      @(posedge clk); #1;
      bus.wr_valid = 1'b0;
      if (gap && i < n) begin
        // Gap cycle; a stray command here must be ignored.
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 4'($urandom);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
      end
    end
    wait_idle("post_write");
    check("wr_beats", wr_addr_q.size(), n + 1);
    for (int i = 0; i < wr_addr_q.size() && i <= n; i++) begin
      ea = a + 4'(i);
      check("wr_addr", wr_addr_q[i], ea);
      check("wr_data", wr_data_q[i], base + 8'(i));
    end
    if (wr_addr_q.size() == n + 1) begin
      check("wr_last_addr", wr_addr_q[n], exp_last);
      check("wr_span", wr_cyc_q[n] - wr_cyc_q[0], gap ? 2 * n : n);
    end
  endtask

  // stall: 0 = rd_ready always high, >0 = low for that many cycles, <0 = random.
  task automatic read_burst(input logic [3:0] a, input logic [3:0] len, input int stall,
                            input logic [3:0] exp_last);
    logic [7:0] exp_q [$];
    logic [3:0] ea;
    int n;
    int cnt;
    n = int'(len);
    wait_idle("pre_read");
    for (int i = 0; i <= n; i++) begin
      ea = a + 4'(i);
      exp_q.push_back(ref_mem[ea]);
    end
    rd_iss_q.delete(); pop_q.delete();
    first_re = -1; first_rv = -1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = a; bus.cmd_len = len;
    bus.rd_ready  = (stall == 0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    cnt = 0;
    while (pop_q.size() < n + 1 && cnt < 300) begin
      if (stall > 0) begin
        if (cnt == stall) begin
          check("stall_issues_le2", int'(rd_iss_q.size() <= 2), 1);
          check("stall_rd_valid", bus.rd_valid, 1);
          check("stall_no_pop", pop_q.size(), 0);
        end
        bus.rd_ready = (cnt >= stall);
      end else if (stall < 0) begin
        bus.rd_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cnt++;
    end
    bus.rd_ready = 1'b0;
    wait_idle("post_read");
    check("rd_beats", pop_q.size(), n + 1);
    check("rd_issues", rd_iss_q.size(), n + 1);
    for (int i = 0; i < pop_q.size() && i <= n; i++) check("rd_data", pop_q[i], exp_q[i]);
    for (int i = 0; i < rd_iss_q.size() && i <= n; i++) begin
      ea = a + 4'(i);
      check("rd_addr", rd_iss_q[i], ea);
    end
    if (rd_iss_q.size() == n + 1) check("rd_last_addr", rd_iss_q[n], exp_last);
    if (stall == 0) check("rd_latency", first_rv - first_re, 2);
  endtask

  typedef struct {
    bit         wr;
    logic [3:0] addr;
    logic [3:0] len;
    logic [7:0] base;
    bit         gap;
    int         stall;
    logic [3:0] exp_last;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] ra, rl, el;
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 4'd0; bus.cmd_len = 4'd0;
    bus.wr_valid = 1'b0; bus.wr_data = 8'd0; bus.rd_ready = 1'b0;
    bus.ram_data_out = 8'd0;

    // wr  addr   len    base    gap   stall exp_last
    tbl[0] = '{1'b1, 4'd3,  4'd3,  8'hA0, 1'b0, 0,  4'd6};
    tbl[1] = '{1'b0, 4'd3,  4'd3,  8'h00, 1'b0, 0,  4'd6};
    tbl[2] = '{1'b1, 4'd14, 4'd3,  8'hB0, 1'b0, 0,  4'd1};
    tbl[3] = '{1'b0, 4'd14, 4'd3,  8'h00, 1'b0, 0,  4'd1};
    tbl[4] = '{1'b1, 4'd8,  4'd7,  8'h40, 1'b1, 0,  4'd15};
    tbl[5] = '{1'b0, 4'd8,  4'd7,  8'h00, 1'b0, 10, 4'd15};
    tbl[6] = '{1'b1, 4'd15, 4'd0,  8'h5A, 1'b0, 0,  4'd15};
    tbl[7] = '{1'b0, 4'd15, 4'd0,  8'h00, 1'b0, 0,  4'd15};
    tbl[8] = '{1'b1, 4'd0,  4'd15, 8'h10, 1'b0, 0,  4'd15};
    tbl[9] = '{1'b0, 4'd5,  4'd15, 8'h00, 1'b0, 0,  4'd4};

    #2 reset = 1'b0;
    #1 check("reset_outputs", out_vec_s, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 check("post_reset_cmd_ready", bus.cmd_ready, 1);
    check("post_reset_busy", bus.busy, 0);

    for (int t = 0; t < 10; t++) begin
      if (tbl[t].wr) write_burst(tbl[t].addr, tbl[t].len, tbl[t].base, tbl[t].gap, tbl[t].exp_last);
      else           read_burst(tbl[t].addr, tbl[t].len, tbl[t].stall, tbl[t].exp_last);
    end

    for (int r = 0; r < 30; r++) begin
      ra = 4'($urandom);
      rl = 4'($urandom);
      el = ra + rl;
      if ($urandom_range(0, 1) == 1) write_burst(ra, rl, 8'($urandom), 1'($urandom_range(0, 1)), el);
      else                           read_burst(ra, rl, -1, el);
    end

    // Reset in the middle of a read burst.
    wait_idle("pre_abort");
    rd_iss_q.delete(); pop_q.delete();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 4'd0; bus.cmd_len = 4'd5;
    bus.rd_ready = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (rd_iss_q.size() >= 3) break;
    end
    check("abort_reached_beat3", int'(rd_iss_q.size() >= 3), 1);
    reset = 1'b0;
    #1 check("abort_reset_outputs", out_vec_s, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 check("abort_cmd_ready", bus.cmd_ready, 1);
    check("abort_rd_valid", bus.rd_valid, 0);
    begin
      int iss0, pop0;
      iss0 = rd_iss_q.size();
      pop0 = pop_q.size();
      repeat (6) @(posedge clk);
      #1;
      check("abort_no_issue", rd_iss_q.size(), iss0);
      check("abort_no_pop", pop_q.size(), pop0);
    end
    bus.rd_ready = 1'b0;

    read_burst(4'd2, 4'd4, 0, 4'd6);

    check("we_re_overlap", both_err, 0);
    check("idle_bus_zero", idle_err, 0);
    check("fifo_overflow", ovf_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
